// File: rtl/wash_pkg.sv
// wash_pkg: definitions shared by the wash panel controller and the washing-machine sequencer.
//   panel_state_t       - panel FSM encoding (SELECT, ARM, RUN, PAUSED)
//   *_DEF               - default debounce length and start-handshake timeout
//   seq_state_t, SEQ_*  - sequencer state encoding and phase durations
package wash_pkg;

    typedef enum logic [1:0] {SELECT, ARM, RUN, PAUSED} panel_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int START_TIMEOUT_DEF   = 8;

    typedef enum logic [2:0] {SEQ_IDLE, SEQ_FILL, SEQ_WASH, SEQ_RINSE, SEQ_SPIN, SEQ_DRY} seq_state_t;

    localparam int SEQ_FILL_CYCLES  = 16;
    localparam int SEQ_WASH_CYCLES  = 64;
    localparam int SEQ_RINSE_CYCLES = 32;
    localparam int SEQ_SPIN_CYCLES  = 32;
    localparam int SEQ_DRY_CYCLES   = 48;

endpackage

// File: rtl/panel_debouncer.sv
// panel_debouncer: 2-flop synchroniser, stability debouncer and rising-edge press pulse.
//   clk, rst - clock, asynchronous active-high reset
//   i_raw    - asynchronous raw level
//   o_level  - debounced level
//   o_press  - one-cycle pulse when the debounced level rises
module panel_debouncer
    import wash_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]       r_sync;
    logic             r_db;
    logic             r_db_d;
    logic [CNT_W-1:0] r_cnt;

    // Any cycle where the synchronised level agrees with db restarts the count,
    // so only an uninterrupted run of DEBOUNCE_CYCLES disagreeing samples flips db.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_db   <= 1'b0;
            r_db_d <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            r_db_d <= r_db;
            if (r_sync[1] == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_db  <= r_sync[1];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_db;
    assign o_press = r_db & ~r_db_d;

endmodule

// File: rtl/wash_panel_controller.sv
// wash_panel_controller: front panel feeding the washing-machine sequencer.
//   clk, rst                         - clock, asynchronous active-high reset
//   btn_start_raw, btn_pause_raw     - raw push-buttons (1 = pressed)
//   door_sensor_raw                  - raw door switch (1 = closed)
//   sel_double, sel_dry              - program selector switches
//   done                             - sequencer idle indication
//   start, double_wash, dry_wash,
//   time_pause, door_closed          - sequencer command inputs
//   lock_door, busy                  - solenoid drive, cycle in progress
//   start_fault                      - sticky: sequencer never left idle after start
//   cycle_complete                   - one-cycle pulse at end of cycle
module wash_panel_controller
    import wash_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int START_TIMEOUT   = START_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_start_raw,
    input  logic btn_pause_raw,
    input  logic door_sensor_raw,
    input  logic sel_double,
    input  logic sel_dry,
    input  logic done,
    output logic start,
    output logic double_wash,
    output logic dry_wash,
    output logic time_pause,
    output logic door_closed,
    output logic lock_door,
    output logic busy,
    output logic start_fault,
    output logic cycle_complete
);

    localparam int WAIT_W = $clog2(START_TIMEOUT);

    panel_state_t      r_state;
    panel_state_t      w_next;
    logic [WAIT_W-1:0] r_wait;
    logic w_start_press, w_pause_press, w_door;
    logic w_start_level_unused, w_pause_level_unused, w_door_press_unused;
    logic w_accept, w_timeout;
    logic r_start, r_double, r_dry, r_pause, r_lock, r_busy, r_fault, r_complete;

    panel_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_btn (
        .clk(clk), .rst(rst), .i_raw(btn_start_raw),
        .o_level(w_start_level_unused), .o_press(w_start_press)
    );

    panel_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_btn (
        .clk(clk), .rst(rst), .i_raw(btn_pause_raw),
        .o_level(w_pause_level_unused), .o_press(w_pause_press)
    );

    panel_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_door (
        .clk(clk), .rst(rst), .i_raw(door_sensor_raw),
        .o_level(w_door), .o_press(w_door_press_unused)
    );

    // done has priority over a simultaneous pause press in RUN/PAUSED.
    always_comb begin
        w_next = r_state;
        case (r_state)
            SELECT:  if (w_start_press && w_door) w_next = ARM;
            ARM:     if (!done) w_next = RUN;
                     else if (r_wait == WAIT_W'(START_TIMEOUT - 1)) w_next = SELECT;
            RUN:     if (done) w_next = SELECT;
                     else if (w_pause_press) w_next = PAUSED;
            PAUSED:  if (done) w_next = SELECT;
                     else if (w_pause_press) w_next = RUN;
            default: w_next = SELECT;
        endcase
    end

    assign w_accept  = (r_state == SELECT) && (w_next == ARM);
    assign w_timeout = (r_state == ARM) && (w_next == SELECT);

    // Outputs are registered from the next state so they change on the same
    // edge as the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= SELECT;
            r_wait     <= '0;
            r_start    <= 1'b0;
            r_double   <= 1'b0;
            r_dry      <= 1'b0;
            r_pause    <= 1'b0;
            r_lock     <= 1'b0;
            r_busy     <= 1'b0;
            r_fault    <= 1'b0;
            r_complete <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_wait     <= (r_state == ARM) ? r_wait + 1'b1 : '0;
            r_start    <= w_next == ARM;
            r_pause    <= w_next == PAUSED;
            r_lock     <= w_next != SELECT;
            r_busy     <= w_next != SELECT;
            r_complete <= (r_state == RUN || r_state == PAUSED) && done;
            if (w_accept) begin
                r_double <= sel_double;
                r_dry    <= sel_dry;
                r_fault  <= 1'b0;
            end else if (w_timeout) begin
                r_fault  <= 1'b1;
            end
        end
    end

    assign start          = r_start;
    assign double_wash    = r_double;
    assign dry_wash       = r_dry;
    assign time_pause     = r_pause;
    assign door_closed    = w_door;
    assign lock_door      = r_lock;
    assign busy           = r_busy;
    assign start_fault    = r_fault;
    assign cycle_complete = r_complete;

endmodule

// File: tb/tb_wash_panel_controller.sv
// tb_wash_panel_controller: scenario tasks with a scoreboard of expected output vectors.
module tb_wash_panel_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_start_raw = 1'b0, btn_pause_raw = 1'b0, door_sensor_raw = 1'b0;
    logic sel_double = 1'b0, sel_dry = 1'b0, done = 1'b1;
    logic start, double_wash, dry_wash, time_pause, door_closed;
    logic lock_door, busy, start_fault, cycle_complete;

    int checks = 0;
    int failures = 0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_v;

    wash_panel_controller #(.DEBOUNCE_CYCLES(4), .START_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .btn_start_raw(btn_start_raw), .btn_pause_raw(btn_pause_raw),
        .door_sensor_raw(door_sensor_raw), .sel_double(sel_double), .sel_dry(sel_dry),
        .done(done), .start(start), .double_wash(double_wash), .dry_wash(dry_wash),
        .time_pause(time_pause), .door_closed(door_closed), .lock_door(lock_door),
        .busy(busy), .start_fault(start_fault), .cycle_complete(cycle_complete)
    );

    always #5 clk = ~clk;

    // Vector order: start, double_wash, dry_wash, time_pause, door_closed, lock_door, busy, start_fault, cycle_complete
    function automatic logic [8:0] outs();
        return {start, double_wash, dry_wash, time_pause, door_closed, lock_door, busy, start_fault, cycle_complete};
    endfunction

    function automatic logic [8:0] mk(input logic st, dbl, dry, tp, dr, lk, bz, flt, cc);
        return {st, dbl, dry, tp, dr, lk, bz, flt, cc};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_to_run(output int ok);
        int t;
        done = 1'b1;
        btn_start_raw = 1'b1;
        t = 0;
        while (!start && t < 30) begin
            tick(1);
            t++;
        end
        ok = int'(start);
        btn_start_raw = 1'b0;
        done = 1'b0;
        tick(9);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            btn_start_raw = 1'($urandom);
            btn_pause_raw = 1'($urandom);
            door_sensor_raw = 1'($urandom);
            sel_double = 1'($urandom);
            sel_dry = 1'($urandom);
            done = 1'($urandom);
            tick(1);
            checks++;
            if (outs() !== 9'b0) begin
                failures++;
                $display("FAIL reset_hold cycle=%0d got=%b exp=%b", i, outs(), 9'b0);
            end
        end
        btn_start_raw = 1'b0;
        btn_pause_raw = 1'b0;
        door_sensor_raw = 1'b1;
        sel_double = 1'b0;
        sel_dry = 1'b0;
        done = 1'b1;
        rst = 1'b0;
        tick(1);
        checks++;
        if (outs() !== 9'b0) begin
            failures++;
            $display("FAIL reset_release got=%b exp=%b", outs(), 9'b0);
        end
        tick(4);
        checks++;
        if (door_closed !== 1'b0) begin
            failures++;
            $display("FAIL door_before_debounce got=%b exp=0", door_closed);
        end
        tick(1);
        checks++;
        if (outs() !== mk(0,0,0,0,1,0,0,0,0)) begin
            failures++;
            $display("FAIL door_debounced got=%b exp=%b", outs(), mk(0,0,0,0,1,0,0,0,0));
        end
    endtask

    task automatic test_program;
        int t, n;
        sel_double = 1'b1;
        sel_dry = 1'b0;
        done = 1'b1;
        exp_q.push_back(mk(1,1,0,0,1,1,1,0,0));
        btn_start_raw = 1'b1;
        t = 0;
        while (!start && t < 30) begin
            tick(1);
            t++;
        end
        exp_v = exp_q.pop_front();
        checks++;
        if (t >= 30 || outs() !== exp_v) begin
            failures++;
            $display("FAIL program_arm got=%b exp=%b waited=%0d", outs(), exp_v, t);
        end
        n = 0;
        for (int i = 0; i < 20 && start; i++) begin
            n++;
            if (n == 3) done = 1'b0;
            tick(1);
        end
        checks++;
        if (n !== 3) begin
            failures++;
            $display("FAIL start_width got=%0d exp=3", n);
        end
        checks++;
        if (outs() !== mk(0,1,0,0,1,1,1,0,0)) begin
            failures++;
            $display("FAIL program_run got=%b exp=%b", outs(), mk(0,1,0,0,1,1,1,0,0));
        end
        tick(5);
        btn_start_raw = 1'b0;
        tick(8);
        checks++;
        if (outs() !== mk(0,1,0,0,1,1,1,0,0)) begin
            failures++;
            $display("FAIL held_button_once got=%b exp=%b", outs(), mk(0,1,0,0,1,1,1,0,0));
        end
        done = 1'b1;
        exp_q.push_back(mk(0,1,0,0,1,0,0,0,1));
        t = 0;
        while (!cycle_complete && t < 5) begin
            tick(1);
            t++;
        end
        exp_v = exp_q.pop_front();
        checks++;
        if (t >= 5 || outs() !== exp_v) begin
            failures++;
            $display("FAIL program_complete got=%b exp=%b", outs(), exp_v);
        end
        tick(1);
        checks++;
        if (cycle_complete !== 1'b0) begin
            failures++;
            $display("FAIL complete_pulse_width got=%b exp=0", cycle_complete);
        end
    endtask

    task automatic test_glitch;
        int t;
        logic seen;
        done = 1'b1;
        for (int w = 1; w <= 3; w++) begin
            btn_start_raw = 1'b1;
            tick(w);
            btn_start_raw = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 12; i++) begin
                tick(1);
                if (busy || start) seen = 1'b1;
            end
            checks++;
            if (seen !== 1'b0) begin
                failures++;
                $display("FAIL glitch_%0d got_arm=%b exp=0", w, seen);
            end
        end
        btn_start_raw = 1'b1;
        t = 0;
        while (!start && t < 20) begin
            tick(1);
            t++;
            if (t == 4) btn_start_raw = 1'b0;
        end
        checks++;
        if (t !== 7) begin
            failures++;
            $display("FAIL arm_latency got=%0d exp=7", t);
        end
        done = 1'b0;
        tick(1);
        done = 1'b1;
        tick(9);
    endtask

    task automatic test_pause;
        int t, ok;
        sel_double = 1'b0;
        sel_dry = 1'b1;
        run_to_run(ok);
        checks++;
        if (ok !== 1) begin
            failures++;
            $display("FAIL pause_setup got=%0d exp=1", ok);
        end
        exp_q.push_back(mk(0,0,1,1,1,1,1,0,0));
        btn_pause_raw = 1'b1;
        t = 0;
        while (!time_pause && t < 20) begin
            tick(1);
            t++;
        end
        btn_pause_raw = 1'b0;
        exp_v = exp_q.pop_front();
        checks++;
        if (t >= 20 || outs() !== exp_v) begin
            failures++;
            $display("FAIL pause_enter got=%b exp=%b", outs(), exp_v);
        end
        tick(8);
        exp_q.push_back(mk(0,0,1,0,1,1,1,0,0));
        btn_pause_raw = 1'b1;
        t = 0;
        while (time_pause && t < 20) begin
            tick(1);
            t++;
        end
        btn_pause_raw = 1'b0;
        exp_v = exp_q.pop_front();
        checks++;
        if (t >= 20 || outs() !== exp_v) begin
            failures++;
            $display("FAIL pause_resume got=%b exp=%b", outs(), exp_v);
        end
        tick(8);
        btn_pause_raw = 1'b1;
        tick(6);
        done = 1'b1;
        exp_q.push_back(mk(0,0,1,0,1,0,0,0,1));
        tick(1);
        btn_pause_raw = 1'b0;
        exp_v = exp_q.pop_front();
        checks++;
        if (outs() !== exp_v) begin
            failures++;
            $display("FAIL pause_done_race got=%b exp=%b", outs(), exp_v);
        end
        tick(8);
        run_to_run(ok);
        btn_pause_raw = 1'b1;
        t = 0;
        while (!time_pause && t < 20) begin
            tick(1);
            t++;
        end
        btn_pause_raw = 1'b0;
        tick(8);
        done = 1'b1;
        exp_q.push_back(mk(0,0,1,0,1,0,0,0,1));
        tick(1);
        exp_v = exp_q.pop_front();
        checks++;
        if (ok !== 1 || t >= 20 || outs() !== exp_v) begin
            failures++;
            $display("FAIL paused_done got=%b exp=%b", outs(), exp_v);
        end
        tick(8);
    endtask

    task automatic test_timeout;
        int t, n, ok;
        done = 1'b1;
        sel_double = 1'b1;
        sel_dry = 1'b1;
        exp_q.push_back(mk(0,1,1,0,1,0,0,1,0));
        btn_start_raw = 1'b1;
        t = 0;
        while (!start && t < 30) begin
            tick(1);
            t++;
        end
        btn_start_raw = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && start; i++) begin
            n++;
            tick(1);
        end
        checks++;
        if (t >= 30 || n !== 8) begin
            failures++;
            $display("FAIL timeout_start_width got=%0d exp=8", n);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if (outs() !== exp_v) begin
            failures++;
            $display("FAIL timeout_fault got=%b exp=%b", outs(), exp_v);
        end
        tick(8);
        sel_double = 1'b0;
        sel_dry = 1'b0;
        run_to_run(ok);
        checks++;
        if (ok !== 1 || outs() !== mk(0,0,0,0,1,1,1,0,0)) begin
            failures++;
            $display("FAIL fault_clear got=%b exp=%b", outs(), mk(0,0,0,0,1,1,1,0,0));
        end
        done = 1'b1;
        tick(2);
    endtask

    task automatic test_door_sel;
        int ok;
        logic seen;
        door_sensor_raw = 1'b0;
        tick(8);
        checks++;
        if (door_closed !== 1'b0) begin
            failures++;
            $display("FAIL door_open got=%b exp=0", door_closed);
        end
        btn_start_raw = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (start || lock_door || busy) seen = 1'b1;
        end
        btn_start_raw = 1'b0;
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL door_open_start got_active=%b exp=0", seen);
        end
        door_sensor_raw = 1'b1;
        tick(8);
        sel_double = 1'b0;
        sel_dry = 1'b1;
        run_to_run(ok);
        sel_dry = 1'b0;
        sel_double = 1'b1;
        tick(4);
        checks++;
        if (ok !== 1 || outs() !== mk(0,0,1,0,1,1,1,0,0)) begin
            failures++;
            $display("FAIL sel_ignored_in_run got=%b exp=%b", outs(), mk(0,0,1,0,1,1,1,0,0));
        end
        done = 1'b1;
        tick(9);
    endtask

    task automatic test_async_reset;
        int ok, t;
        run_to_run(ok);
        btn_pause_raw = 1'b1;
        t = 0;
        while (!time_pause && t < 20) begin
            tick(1);
            t++;
        end
        btn_pause_raw = 1'b0;
        checks++;
        if (ok !== 1 || t >= 20 || busy !== 1'b1) begin
            failures++;
            $display("FAIL async_setup got_busy=%b exp=1", busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (outs() !== 9'b0) begin
            failures++;
            $display("FAIL async_reset got=%b exp=%b", outs(), 9'b0);
        end
        tick(2);
        rst = 1'b0;
        tick(1);
        checks++;
        if (outs() !== 9'b0) begin
            failures++;
            $display("FAIL post_reset got=%b exp=%b", outs(), 9'b0);
        end
        tick(5);
        checks++;
        if (outs() !== mk(0,0,0,0,1,0,0,0,0)) begin
            failures++;
            $display("FAIL post_reset_door got=%b exp=%b", outs(), mk(0,0,0,0,1,0,0,0,0));
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_glitch();
        test_pause();
        test_timeout();
        test_door_sel();
        test_async_reset();
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
